multicycle_ctrl: RTL and testbench

Sequencing control unit for the multi-cycle RV32I datapath. It replaces single-cycle opcode decode with a FETCH/DECODE/EXECUTE/MEM/WB state machine. Instruction and data memory use req/ready handshakes with a bounded wait, and illegal opcodes or memory timeouts trap. The same datapath control fields are presented (ALUOp, RegSrc, ALUSrc, RegWrite, MemRead, MemWrite, Branch, Jump), now qualified per state, plus PC/IR write enables and a retire pulse.

---
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control-unit bundle between the multi-cycle sequencer and the RV32I datapath/memories.
// The master side is the sequencer; the slave side is the datapath or a test driver.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       dmem_req;
    logic       IRWrite;
    logic       PCWrite;
    logic       retire;
    logic [1:0] ALUOp;
    logic [1:0] RegSrc;
    logic       ALUSrc;
    logic       MemRead;
    logic       MemWrite;
    logic       Branch;
    logic       Jump;
    logic       RegWrite;
    logic [2:0] state;
    logic       trap;
    logic [1:0] trap_cause;

    modport master (
        input  opcode, imem_ready, dmem_ready,
        output imem_req, dmem_req, IRWrite, PCWrite, retire, ALUOp, RegSrc,
               ALUSrc, MemRead, MemWrite, Branch, Jump, RegWrite, state, trap, trap_cause
    );

    modport slave (
        output opcode, imem_ready, dmem_ready,
        input  imem_req, dmem_req, IRWrite, PCWrite, retire, ALUOp, RegSrc,
               ALUSrc, MemRead, MemWrite, Branch, Jump, RegWrite, state, trap, trap_cause
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXECUTE/MEM/WB sequencer for the multi-cycle RV32I datapath with bounded memory waits and traps.
// Outputs are combinational from (state, op_q); memory stalls hold the state until ready or timeout.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC = 3'd2,
        ST_MEM = 3'd3,
        ST_WB = 3'd4,
        ST_TRAP = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    op_q;
    logic [CW-1:0] wait_cnt;
    logic          trap_q;
    logic [1:0]    cause_q, cause_d;
    logic          tmo_hit;

    logic       imem_req, dmem_req, ir_wr, pc_wr, reg_wr;
    logic       mem_rd, mem_wr, branch, jump, alu_src;
    logic [1:0] alu_op, reg_src;

    function automatic logic is_known(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LD, OP_JALR, OP_S, OP_LUI,
            OP_AUIPC, OP_JAL, OP_B, OP_FENCE: is_known = 1'b1;
            default:                          is_known = 1'b0;
        endcase
    endfunction

    assign tmo_hit = (MEM_TIMEOUT > 0) && (wait_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
            trap_q   <= 1'b0;
            cause_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE)
                op_q <= bus.opcode;
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (state_q == ST_FETCH || state_q == ST_MEM)
                wait_cnt <= wait_cnt + CW'(1);
            if (state_d == ST_TRAP && state_q != ST_TRAP) begin
                trap_q  <= 1'b1;
                cause_q <= cause_d;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_wr    = 1'b0;
        pc_wr    = 1'b0;
        reg_wr   = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        alu_src  = 1'b0;
        alu_op   = 2'd0;
        reg_src  = 2'd0;

        // Static datapath fields follow op_q only while an instruction is in flight past DECODE.
        if (state_q inside {ST_EXEC, ST_MEM, ST_WB}) begin
            case (op_q)
                OP_I:     alu_src = 1'b1;
                OP_LD:    begin alu_op = 2'd1; alu_src = 1'b1; reg_src = 2'd1; end
                OP_JALR:  begin alu_src = 1'b1; reg_src = 2'd3; end
                OP_S:     begin alu_op = 2'd1; alu_src = 1'b1; end
                OP_LUI:   begin alu_op = 2'd1; alu_src = 1'b1; end
                OP_AUIPC: reg_src = 2'd2;
                OP_JAL:   reg_src = 2'd3;
                OP_B:     alu_op = 2'd2;
                default:  ;
            endcase
        end

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_wr   = 1'b1;
                    state_d = ST_DECODE;
                end else if (tmo_hit) begin
                    state_d = ST_TRAP;
                    cause_d = 2'd2;
                end
            end
            ST_DECODE: begin
                if (!is_known(bus.opcode) && (ILLEGAL_TRAP != 0)) begin
                    state_d = ST_TRAP;
                    cause_d = 2'd1;
                end else if (bus.opcode == OP_FENCE || !is_known(bus.opcode)) begin
                    pc_wr   = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_q == OP_LD || op_q == OP_S) begin
                    state_d = ST_MEM;
                end else if (op_q == OP_B) begin
                    branch  = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                mem_rd   = (op_q == OP_LD);
                mem_wr   = (op_q == OP_S);
                if (bus.dmem_ready) begin
                    if (op_q == OP_LD) begin
                        state_d = ST_WB;
                    end else begin
                        pc_wr   = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_TRAP;
                    cause_d = 2'd3;
                end
            end
            ST_WB: begin
                reg_wr  = 1'b1;
                pc_wr   = 1'b1;
                jump    = (op_q == OP_JAL || op_q == OP_JALR);
                state_d = ST_FETCH;
            end
            default: ;
        endcase
    end

    // Reset masks every output, including the state code and sticky trap.
    assign bus.imem_req   = !rst && imem_req;
    assign bus.dmem_req   = !rst && dmem_req;
    assign bus.IRWrite    = !rst && ir_wr;
    assign bus.PCWrite    = !rst && pc_wr;
    assign bus.retire     = !rst && pc_wr;
    assign bus.RegWrite   = !rst && reg_wr;
    assign bus.MemRead    = !rst && mem_rd;
    assign bus.MemWrite   = !rst && mem_wr;
    assign bus.Branch     = !rst && branch;
    assign bus.Jump       = !rst && jump;
    assign bus.ALUSrc     = !rst && alu_src;
    assign bus.ALUOp      = rst ? 2'd0 : alu_op;
    assign bus.RegSrc     = rst ? 2'd0 : reg_src;
    assign bus.state      = rst ? 3'd0 : state_q;
    assign bus.trap       = !rst && trap_q;
    assign bus.trap_cause = rst ? 2'd0 : cause_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: per-cycle expected control vectors are queued with their stimulus and compared mid-cycle.
module tb_multicycle_ctrl;
    localparam int TMO = 16;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req, dmem_req, IRWrite, PCWrite, retire;
        logic [1:0] ALUOp, RegSrc;
        logic       ALUSrc, MemRead, MemWrite, Branch, Jump, RegWrite, trap;
        logic [1:0] trap_cause;
    } obs_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       ir, dr;
        obs_t       ea;
        bit         chk_b;
        obs_t       eb;
    } cyc_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    cyc_t sb[$];

    multicycle_ctrl_if bus_a ();
    multicycle_ctrl_if bus_b ();

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .ILLEGAL_TRAP(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .ILLEGAL_TRAP(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    obs_t got_a, got_b;
    assign got_a = {bus_a.state, bus_a.imem_req, bus_a.dmem_req, bus_a.IRWrite, bus_a.PCWrite,
                    bus_a.retire, bus_a.ALUOp, bus_a.RegSrc, bus_a.ALUSrc, bus_a.MemRead,
                    bus_a.MemWrite, bus_a.Branch, bus_a.Jump, bus_a.RegWrite, bus_a.trap,
                    bus_a.trap_cause};
    assign got_b = {bus_b.state, bus_b.imem_req, bus_b.dmem_req, bus_b.IRWrite, bus_b.PCWrite,
                    bus_b.retire, bus_b.ALUOp, bus_b.RegSrc, bus_b.ALUSrc, bus_b.MemRead,
                    bus_b.MemWrite, bus_b.Branch, bus_b.Jump, bus_b.RegWrite, bus_b.trap,
                    bus_b.trap_cause};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%06h expected 0x%06h", tag, got, exp);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    function automatic obs_t idle(input logic [2:0] st);
        obs_t e;
        e = '0;
        e.state = st;
        return e;
    endfunction

    task automatic push2(input logic r, input logic [6:0] op, input logic ir, input logic dr,
                         input obs_t ea, input bit chk_b, input obs_t eb);
        cyc_t c;
        c.rst = r; c.op = op; c.ir = ir; c.dr = dr; c.ea = ea; c.chk_b = chk_b; c.eb = eb;
        sb.push_back(c);
    endtask

    task automatic push(input logic r, input logic [6:0] op, input logic ir, input logic dr, input obs_t ea);
        push2(r, op, ir, dr, ea, 1'b0, '0);
    endtask

    task automatic rst_cycle(input bit chk_b);
        push2(1'b1, rop(), rbit(), rbit(), '0, chk_b, '0);
    endtask

    task automatic trap_hold(input logic [1:0] cause, input int n);
        obs_t e;
        e = idle(3'd5);
        e.trap = 1'b1;
        e.trap_cause = cause;
        for (int i = 0; i < n; i++) push(1'b0, rop(), rbit(), rbit(), e);
    endtask

    // Reference field table: {ALUOp, RegSrc, ALUSrc} for each known opcode.
    task automatic fields(input logic [6:0] op, output logic [1:0] aop, output logic [1:0] rs,
                          output logic asrc, output bit known);
        aop = 2'd0; rs = 2'd0; asrc = 1'b0; known = 1'b1;
        case (op)
            OP_R:     ;
            OP_I:     asrc = 1'b1;
            OP_LD:    begin aop = 2'd1; asrc = 1'b1; rs = 2'd1; end
            OP_JALR:  begin asrc = 1'b1; rs = 2'd3; end
            OP_S:     begin aop = 2'd1; asrc = 1'b1; end
            OP_LUI:   begin aop = 2'd1; asrc = 1'b1; end
            OP_AUIPC: rs = 2'd2;
            OP_JAL:   rs = 2'd3;
            OP_B:     aop = 2'd2;
            OP_FENCE: ;
            default:  known = 1'b0;
        endcase
    endtask

    // One instruction on dut_a: iw/dw are memory-stall cycles; TMO or more means a timeout trap.
    task automatic instr(input logic [6:0] op, input int iw, input int dw);
        obs_t e;
        logic [1:0] aop, rs;
        logic asrc;
        bit known;
        fields(op, aop, rs, asrc, known);
        e = idle(3'd0);
        e.imem_req = 1'b1;
        for (int i = 0; i < iw && i < TMO; i++) push(1'b0, rop(), 1'b0, rbit(), e);
        if (iw >= TMO) begin trap_hold(2'd2, 3); return; end
        e.IRWrite = 1'b1;
        push(1'b0, rop(), 1'b1, rbit(), e);
        e = idle(3'd1);
        if (op == OP_FENCE) begin
            e.PCWrite = 1'b1; e.retire = 1'b1;
            push(1'b0, op, rbit(), rbit(), e);
            return;
        end
        push(1'b0, op, rbit(), rbit(), e);
        if (!known) begin trap_hold(2'd1, 3); return; end
        e = idle(3'd2);
        e.ALUOp = aop; e.RegSrc = rs; e.ALUSrc = asrc;
        if (op == OP_B) begin
            e.Branch = 1'b1; e.PCWrite = 1'b1; e.retire = 1'b1;
            push(1'b0, rop(), rbit(), rbit(), e);
            return;
        end
        push(1'b0, rop(), rbit(), rbit(), e);
        if (op == OP_LD || op == OP_S) begin
            e.state = 3'd3; e.dmem_req = 1'b1;
            e.MemRead = (op == OP_LD); e.MemWrite = (op == OP_S);
            for (int i = 0; i < dw && i < TMO; i++) push(1'b0, rop(), rbit(), 1'b0, e);
            if (dw >= TMO) begin trap_hold(2'd3, 3); return; end
            if (op == OP_S) begin
                e.PCWrite = 1'b1; e.retire = 1'b1;
                push(1'b0, rop(), rbit(), 1'b1, e);
                return;
            end
            push(1'b0, rop(), rbit(), 1'b1, e);
            e.dmem_req = 1'b0; e.MemRead = 1'b0;
        end
        e.state = 3'd4; e.RegWrite = 1'b1; e.PCWrite = 1'b1; e.retire = 1'b1;
        e.Jump = (op == OP_JAL || op == OP_JALR);
        push(1'b0, rop(), rbit(), rbit(), e);
    endtask

    task automatic build();
        obs_t ea, eb, ta;
        rst_cycle(1'b0);
        rst_cycle(1'b0);
        instr(OP_R, 0, 0);
        instr(OP_LD, 0, 3);
        instr(OP_B, 0, 0);
        instr(OP_S, 0, 0);
        instr(OP_I, 0, 0);
        instr(OP_LUI, 0, 0);
        instr(OP_AUIPC, 0, 0);
        instr(OP_JAL, 1, 0);
        instr(OP_JALR, 0, 0);
        instr(OP_FENCE, 2, 0);
        instr(OP_R, TMO - 1, 0);
        instr(OP_LD, 0, TMO - 1);
        instr(OP_S, 0, 2);

        // Reset lands while a store waits in MEM: it must never write memory or retire.
        ea = idle(3'd0); ea.imem_req = 1'b1; ea.IRWrite = 1'b1;
        push(1'b0, rop(), 1'b1, rbit(), ea);
        push(1'b0, OP_S, rbit(), rbit(), idle(3'd1));
        ea = idle(3'd2); ea.ALUOp = 2'd1; ea.ALUSrc = 1'b1;
        push(1'b0, rop(), rbit(), rbit(), ea);
        ea.state = 3'd3; ea.dmem_req = 1'b1; ea.MemWrite = 1'b1;
        push(1'b0, rop(), rbit(), 1'b0, ea);
        push(1'b1, rop(), rbit(), 1'b1, '0);
        instr(OP_R, 0, 0);

        // Illegal opcode: dut_a traps, dut_b (ILLEGAL_TRAP=0) retires it as a 2-cycle NOP.
        rst_cycle(1'b1);
        ea = idle(3'd0); ea.imem_req = 1'b1; ea.IRWrite = 1'b1;
        push2(1'b0, rop(), 1'b1, rbit(), ea, 1'b1, ea);
        eb = idle(3'd1); eb.PCWrite = 1'b1; eb.retire = 1'b1;
        push2(1'b0, OP_BAD, rbit(), rbit(), idle(3'd1), 1'b1, eb);
        ta = idle(3'd5); ta.trap = 1'b1; ta.trap_cause = 2'd1;
        push2(1'b0, rop(), 1'b1, rbit(), ta, 1'b1, ea);
        push2(1'b0, OP_BAD, rbit(), rbit(), ta, 1'b1, eb);
        trap_hold(2'd1, 3);
        rst_cycle(1'b0);

        instr(OP_R, TMO, 0);
        rst_cycle(1'b0);
        instr(OP_LD, 0, TMO);
        rst_cycle(1'b0);
        instr(OP_JAL, 0, 0);
    endtask

    initial begin
        cyc_t c;
        int cyc;
        cyc = 0;
        build();
        while (sb.size() > 0) begin
            c = sb.pop_front();
            rst = c.rst;
            bus_a.opcode = c.op; bus_a.imem_ready = c.ir; bus_a.dmem_ready = c.dr;
            bus_b.opcode = c.op; bus_b.imem_ready = c.ir; bus_b.dmem_ready = c.dr;
            @(negedge clk);
            check($sformatf("cyc%0d dut_a st%0d", cyc, c.ea.state), 32'(got_a), 32'(c.ea));
            if (c.chk_b)
                check($sformatf("cyc%0d dut_b st%0d", cyc, c.eb.state), 32'(got_b), 32'(c.eb));
            @(posedge clk);
            #1;
            cyc++;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
